// File: rtl/pscan_pkg.sv
// Shared types and constants for the pattern scan controller and its 1101 detector.
package pscan_pkg;

    localparam int unsigned STAT_W = 16;

    // Moore recognizer states; S4 means "1101 just completed".
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } det_state_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/pattern_det_core.sv
// Serial Moore recognizer for the bit pattern 1101 with overlap.
// y is registered: it is high while the state is S4.
module pattern_det_core
    import pscan_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic a,
    output logic y
);

    det_state_e state_q;
    det_state_e state_d;

    // Next-state decode; clr restarts the search so patterns never span words.
    always_comb begin
        state_d = S0;
        case (state_q)
            S0:      state_d = a ? S1 : S0;
            S1:      state_d = a ? S2 : S0;
            S2:      state_d = a ? S2 : S3;
            S3:      state_d = a ? S4 : S0;
            S4:      state_d = a ? S2 : S0;
            default: state_d = S0;
        endcase
        if (clr) begin
            state_d = S0;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    assign y = (state_q == S4);

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Round-robin scheduler sharing one serial 1101 detector between two requesters.
// Optional PSCAN_STATS_EN adds saturating word/hit counters on result handshakes.
module pattern_scan_ctrl
    import pscan_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = $clog2(W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [W-1:0]      req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [W-1:0]      req1_data,
    output logic              req1_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_id,
    output logic [CW-1:0]     res_count,
`ifdef PSCAN_STATS_EN
    output logic [STAT_W-1:0] stat_words,
    output logic [STAT_W-1:0] stat_hits,
`endif
    output logic              res_hit
);

    localparam int unsigned BW = $clog2(W);
    localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

    ctrl_state_e   state_q;
    ctrl_state_e   state_d;
    logic          last_id_q;
    logic [W-1:0]  shift_q;
    logic [BW-1:0] bit_cnt_q;
    logic          res_id_q;
    logic [CW-1:0] res_count_q;

    logic grant0;
    logic grant1;
    logic accept;
    logic accept_id;
    logic res_fire;
    logic last_bit;
    logic det_a;
    logic det_y;

    // Arbitration: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_id_q);
        grant1 = req1_valid && (!req0_valid || !last_id_q);
    end

    // Ready is masked while reset is held so no word is taken that reset would discard.
    assign req0_ready = reset && (state_q == IDLE) && grant0;
    assign req1_ready = reset && (state_q == IDLE) && grant1;
    assign accept     = req0_ready || req1_ready;
    assign accept_id  = req1_ready;
    assign res_fire   = (state_q == DONE) && res_ready;
    assign last_bit   = (bit_cnt_q == LAST_BIT);
    assign det_a      = (state_q == SCAN) && shift_q[W-1];

    pattern_det_core u_det (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .a     (det_a),
        .y     (det_y)
    );

    // Controller next-state: accept -> W scan edges -> one flush edge -> hold result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SCAN;
            SCAN:    if (last_bit) state_d = FLUSH;
            FLUSH:   state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Word shifter, bit counter, RR pointer and result accumulator.
    // y lags the input bit by one edge, so the flush edge picks up a match on the LSB.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_id_q   <= 1'b1;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            res_id_q    <= 1'b0;
            res_count_q <= '0;
        end else if (accept) begin
            shift_q     <= accept_id ? req1_data : req0_data;
            bit_cnt_q   <= '0;
            res_id_q    <= accept_id;
            last_id_q   <= accept_id;
            res_count_q <= '0;
        end else if (state_q == SCAN) begin
            shift_q     <= {shift_q[W-2:0], 1'b0};
            bit_cnt_q   <= bit_cnt_q + 1'b1;
            res_count_q <= res_count_q + CW'(det_y);
        end else if (state_q == FLUSH) begin
            res_count_q <= res_count_q + CW'(det_y);
        end
    end

    assign res_valid = (state_q == DONE);
    assign res_id    = res_id_q;
    assign res_count = res_count_q;
    assign res_hit   = (res_count_q != '0);

`ifdef PSCAN_STATS_EN
    logic [STAT_W-1:0] stat_words_q;
    logic [STAT_W-1:0] stat_hits_q;

    // Saturating counters of delivered results and of delivered results with a hit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_words_q <= '0;
            stat_hits_q  <= '0;
        end else if (res_fire) begin
            if (stat_words_q != '1) begin
                stat_words_q <= stat_words_q + 1'b1;
            end
            if (res_hit && (stat_hits_q != '1)) begin
                stat_hits_q <= stat_hits_q + 1'b1;
            end
        end
    end

    assign stat_words = stat_words_q;
    assign stat_hits  = stat_hits_q;
`else
    logic unused_fire;
    assign unused_fire = res_fire;
`endif

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl: vector table plus backpressure, reset and stats sequences.
module tb_pattern_scan_ctrl;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          req0_valid;
    logic [W-1:0]  req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [W-1:0]  req1_data;
    logic          req1_ready;
    logic          res_valid;
    logic          res_ready;
    logic          res_id;
    logic [CW-1:0] res_count;
    logic          res_hit;
`ifdef PSCAN_STATS_EN
    logic [15:0]   stat_words;
    logic [15:0]   stat_hits;
`endif

    int checks = 0;
    int errors = 0;

    pattern_scan_ctrl #(
        .W  (W),
        .CW (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_count  (res_count),
`ifdef PSCAN_STATS_EN
        .stat_words (stat_words),
        .stat_hits  (stat_hits),
`endif
        .res_hit    (res_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       exp_id;
        int         exp_count;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present a request, confirm the grant, measure latency, check and consume the result.
    task automatic serve(input logic v0, input logic [7:0] d0, input logic v1,
                         input logic [7:0] d1, input logic exp_id, input int exp_count,
                         input string tag);
        int waitc;
        int lat;
        @(negedge clk);
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        res_ready  = 1'b1;
        #1;
        waitc = 0;
        while (!(req0_ready || req1_ready) && waitc < 40) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        check({tag, " grant_seen"}, int'(req0_ready || req1_ready), 1);
        check({tag, " grant_id"}, int'(req1_ready), int'(exp_id));
        check({tag, " grant_onehot"}, int'(req0_ready && req1_ready), 0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, lat, W + 1);
        check({tag, " res_id"}, int'(res_id), int'(exp_id));
        check({tag, " res_count"}, int'(res_count), exp_count);
        check({tag, " res_hit"}, int'(res_hit), int'(exp_count != 0));
        @(posedge clk);
        #1;
        check({tag, " valid_drop"}, int'(res_valid), 0);
    endtask

    initial begin
        int lat;
        int spurious;

        vecs[0]  = '{1'b1, 8'hD0, 1'b1, 8'h00, 1'b0, 1};
        vecs[1]  = '{1'b1, 8'hD0, 1'b1, 8'h00, 1'b1, 0};
        vecs[2]  = '{1'b1, 8'hD0, 1'b1, 8'h00, 1'b0, 1};
        vecs[3]  = '{1'b1, 8'hDA, 1'b0, 8'h00, 1'b0, 2};
        vecs[4]  = '{1'b1, 8'h06, 1'b0, 8'h00, 1'b0, 0};
        vecs[5]  = '{1'b1, 8'h80, 1'b0, 8'h00, 1'b0, 0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 8'h0D, 1'b1, 1};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 0};
        vecs[8]  = '{1'b1, 8'hB6, 1'b1, 8'h6D, 1'b0, 1};
        vecs[9]  = '{1'b1, 8'hB6, 1'b1, 8'h6D, 1'b1, 2};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 8'hDD, 1'b1, 2};
        vecs[11] = '{1'b1, 8'hDB, 1'b0, 8'h00, 1'b0, 2};

        // Reset with both requesters asserting: nothing may be granted.
        reset      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 8'h00;
        req1_data  = 8'h00;
        res_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst req0_ready", int'(req0_ready), 0);
        check("rst req1_ready", int'(req1_ready), 0);
        check("rst res_valid", int'(res_valid), 0);
        check("rst res_id", int'(res_id), 0);
        check("rst res_count", int'(res_count), 0);
        check("rst res_hit", int'(res_hit), 0);
`ifdef PSCAN_STATS_EN
        check("rst stat_words", int'(stat_words), 0);
        check("rst stat_hits", int'(stat_hits), 0);
`endif
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset      = 1'b1;

        for (int i = 0; i < 12; i++) begin
            serve(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].exp_id,
                  vecs[i].exp_count, $sformatf("vec%0d", i));
        end

        // Backpressure: result must hold while res_ready is low; no new grants.
        @(negedge clk);
        res_ready  = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 8'hDA;
        req1_valid = 1'b0;
        #1;
        check("bp grant0", int'(req0_ready), 1);
        @(posedge clk);
        #1;
        req1_valid = 1'b1;
        req1_data  = 8'hFF;
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp latency", lat, W + 1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("bp hold%0d valid", i), int'(res_valid), 1);
            check($sformatf("bp hold%0d id", i), int'(res_id), 0);
            check($sformatf("bp hold%0d count", i), int'(res_count), 2);
            check($sformatf("bp hold%0d readies", i), int'(req0_ready || req1_ready), 0);
            if (i < 5) begin
                @(posedge clk);
                #1;
            end
        end
        res_ready = 1'b1;
        #1;
        check("bp handshake_cycle readies", int'(req0_ready || req1_ready), 0);
        @(posedge clk);
        #1;
        check("bp after valid", int'(res_valid), 0);
        check("bp after req1_ready", int'(req1_ready), 1);
        check("bp after req0_ready", int'(req0_ready), 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("bp dropped readies", int'(req0_ready || req1_ready), 0);

        // Reset during SCAN cycle 4 of a req0 word; pointer must return to req0 priority.
        @(negedge clk);
        req0_valid = 1'b1;
        req0_data  = 8'hDA;
        #1;
        check("mrst grant0", int'(req0_ready), 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 8'hDA;
        req1_data  = 8'h00;
        @(posedge clk);
        #1;
        check("mrst res_valid", int'(res_valid), 0);
        check("mrst res_id", int'(res_id), 0);
        check("mrst res_count", int'(res_count), 0);
        check("mrst res_hit", int'(res_hit), 0);
        check("mrst readies", int'(req0_ready || req1_ready), 0);
        reset = 1'b1;
        #1;
        check("mrst prio req0", int'(req0_ready), 1);
        check("mrst prio req1", int'(req1_ready), 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        spurious = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(posedge clk);
            #1;
            if (res_valid) spurious++;
        end
        check("mrst no_result", spurious, 0);

        serve(1'b1, 8'hDA, 1'b1, 8'h00, 1'b0, 2, "post0");
        serve(1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 0, "post1");
        serve(1'b1, 8'hD0, 1'b0, 8'h00, 1'b0, 1, "post2");

`ifdef PSCAN_STATS_EN
        check("stat words", int'(stat_words), 3);
        check("stat hits", int'(stat_hits), 2);
        force dut.stat_words_q = 16'hFFFF;
        force dut.stat_hits_q  = 16'hFFFF;
        #1;
        release dut.stat_words_q;
        release dut.stat_hits_q;
        serve(1'b1, 8'hDA, 1'b0, 8'h00, 1'b0, 2, "sat");
        check("stat words sat", int'(stat_words), 16'hFFFF);
        check("stat hits sat", int'(stat_hits), 16'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
